// File: rtl/sw_input_cond_if.sv
// -----------------------------------------------------------------------------
// sw_input_cond_if
//   Bundles the switch conditioner's data/control signals so the conditioner
//   and whatever drives or observes it share one port.
//
//   Signals:
//     sw_raw_i      [NUM_SW-1:0]  raw asynchronous switch pins
//     clr_i                       synchronous clear of all sticky change flags
//     sw_o          [31:0]        debounced switch word (zero-extended)
//     sw_rise_o     [31:0]        one-cycle pulse on a debounced 0->1
//     sw_fall_o     [31:0]        one-cycle pulse on a debounced 1->0
//     sw_changed_o  [31:0]        sticky per-bit change flag
//
//   Modports:
//     slave   - the conditioner (consumes raw pins / clear, drives outputs)
//     master  - the environment (drives raw pins / clear, observes outputs)
// -----------------------------------------------------------------------------
interface sw_input_cond_if #(
    parameter int NUM_SW = 18
);
    logic [NUM_SW-1:0] sw_raw_i;
    logic              clr_i;
    logic [31:0]       sw_o;
    logic [31:0]       sw_rise_o;
    logic [31:0]       sw_fall_o;
    logic [31:0]       sw_changed_o;

    modport slave (
        input  sw_raw_i,
        input  clr_i,
        output sw_o,
        output sw_rise_o,
        output sw_fall_o,
        output sw_changed_o
    );

    modport master (
        output sw_raw_i,
        output clr_i,
        input  sw_o,
        input  sw_rise_o,
        input  sw_fall_o,
        input  sw_changed_o
    );
endinterface

// File: rtl/sw_input_cond.sv
// -----------------------------------------------------------------------------
// sw_input_cond
//   Conditions raw board slide switches for the core's 32-bit switch input.
//   Each switch goes through a 2-flop synchronizer followed by a counter-based
//   debouncer; the debounced word is zero-extended to 32 bits.
//
//   Optional feature (macro SW_INPUT_COND_EDGE_EN):
//     defined   - registered per-bit rise/fall pulses and sticky change flags
//                 (cleared by clr_i, a coincident transition wins over clear).
//     undefined - edge/sticky logic is not built, those outputs are tied to 0
//                 and clr_i is ignored. sw_o is unaffected.
//
//   Ports:
//     clk_i    core clock
//     rst_ni   asynchronous active-low reset, clears all state
//     bus      sw_input_cond_if.slave (sw_raw_i, clr_i, sw_o, sw_rise_o,
//              sw_fall_o, sw_changed_o)
//
//   Parameters:
//     NUM_SW        number of switches, 1..32
//     DEBOUNCE_CYC  consecutive stable cycles before an output bit flips, >= 1
// -----------------------------------------------------------------------------
module sw_input_cond #(
    parameter int NUM_SW       = 18,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    sw_input_cond_if.slave     bus
);

    localparam int              CNT_W    = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Zero-extend an NUM_SW-wide vector onto the 32-bit output bus.
    function automatic logic [31:0] zext(input logic [NUM_SW-1:0] v);
        logic [31:0] w;
        w             = '0;
        w[NUM_SW-1:0] = v;
        return w;
    endfunction

    logic [NUM_SW-1:0] r_sync1;
    logic [NUM_SW-1:0] r_sync2;
    logic [NUM_SW-1:0] r_stable;
    logic [CNT_W-1:0]  r_cnt       [NUM_SW];

    logic [NUM_SW-1:0] w_stable_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt   [NUM_SW];

    // ---- stage 1/2: synchronizer ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.sw_raw_i;
            r_sync2 <= r_sync1;
        end
    end

    // ---- stage 3: debounce ----
    // The count restarts whenever the synchronized level matches the stable
    // level, so any bounce back discards progress. The counter stops at
    // CNT_LAST and is cleared in the same edge the stable value flips, so it
    // can never wrap.
    always_comb begin
        w_stable_nxt = r_stable;
        for (int i = 0; i < NUM_SW; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_stable_nxt[i] = r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stable <= '0;
            r_cnt    <= '{default: '0};
        end else begin
            r_stable <= w_stable_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign bus.sw_o = zext(r_stable);

`ifdef SW_INPUT_COND_EDGE_EN
    logic [NUM_SW-1:0] r_rise;
    logic [NUM_SW-1:0] r_fall;
    logic [NUM_SW-1:0] r_changed;
    logic [NUM_SW-1:0] w_rise_nxt;
    logic [NUM_SW-1:0] w_fall_nxt;

    // Pulses are derived from the next stable value so they register in the
    // same edge that sw_o first shows the new level.
    assign w_rise_nxt = w_stable_nxt & ~r_stable;
    assign w_fall_nxt = ~w_stable_nxt & r_stable;

    // ---- stage 4: edge pulses and sticky flags ----
    // Clear is applied before OR-ing in new transitions, so a transition in
    // the clearing cycle leaves its bit set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= '0;
        end else begin
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            r_changed <= (bus.clr_i ? '0 : r_changed) | w_rise_nxt | w_fall_nxt;
        end
    end

    assign bus.sw_rise_o    = zext(r_rise);
    assign bus.sw_fall_o    = zext(r_fall);
    assign bus.sw_changed_o = zext(r_changed);
`else
    logic w_unused_clr;

    assign w_unused_clr     = bus.clr_i;
    assign bus.sw_rise_o    = '0;
    assign bus.sw_fall_o    = '0;
    assign bus.sw_changed_o = '0;
`endif

endmodule

// File: tb/tb_sw_input_cond.sv
// -----------------------------------------------------------------------------
// tb_sw_input_cond
//   Directed bench for sw_input_cond with NUM_SW=18, DEBOUNCE_CYC=4.
//   Expected edge/sticky values follow SW_INPUT_COND_EDGE_EN: when the macro is
//   undefined those outputs are expected to stay 0.
// -----------------------------------------------------------------------------
module tb_sw_input_cond;

    localparam int NUM_SW       = 18;
    localparam int DEBOUNCE_CYC = 4;
    localparam int LAT          = DEBOUNCE_CYC + 2;

`ifdef SW_INPUT_COND_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int n_chk  = 0;
    int n_fail = 0;
    int n_rise = 0;
    int n_fall = 0;
    int rise0;
    int fall0;

    sw_input_cond_if #(.NUM_SW(NUM_SW)) u_if ();

    sw_input_cond #(
        .NUM_SW       (NUM_SW),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles in which any rise/fall pulse is visible.
    always @(negedge clk) begin
        if (u_if.sw_rise_o != 32'h0) n_rise++;
        if (u_if.sw_fall_o != 32'h0) n_fall++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] e(input logic [31:0] v);
        return EDGE ? v : 32'h0;
    endfunction

    // Reset with raw pins at 'raw', then release just after an edge so the
    // next rising edge is the first one that samples the pins.
    task automatic do_reset(input logic [NUM_SW-1:0] raw);
        rst_n          = 1'b0;
        u_if.sw_raw_i  = raw;
        u_if.clr_i     = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b1;
        u_if.sw_raw_i = '0;
        u_if.clr_i    = 1'b0;
        #2;

        // ---- reset with all switches high ----
        rst_n         = 1'b0;
        u_if.sw_raw_i = 18'h3FFFF;
        #1;
        check("rst_async_sw", u_if.sw_o, 32'h0);
        tick(3);
        check("rst_sw",      u_if.sw_o,         32'h0);
        check("rst_rise",    u_if.sw_rise_o,    32'h0);
        check("rst_fall",    u_if.sw_fall_o,    32'h0);
        check("rst_changed", u_if.sw_changed_o, 32'h0);
        rst_n = 1'b1;
        tick(LAT - 1);
        check("rst_sw_edge5", u_if.sw_o, 32'h0);
        tick(1);
        check("rst_sw_edge6",  u_if.sw_o,         32'h0003FFFF);
        check("rst_rise_e6",   u_if.sw_rise_o,    e(32'h0003FFFF));
        check("rst_chg_e6",    u_if.sw_changed_o, e(32'h0003FFFF));
        tick(1);
        check("rst_rise_e7",   u_if.sw_rise_o,    32'h0);
        check("rst_sw_e7",     u_if.sw_o,         32'h0003FFFF);

        // ---- clean change on bit 3 ----
        do_reset('0);
        tick(2);
        u_if.sw_raw_i = 18'h00008;
        tick(LAT - 1);
        check("clean_sw_e5",   u_if.sw_o,         32'h0);
        tick(1);
        check("clean_sw_e6",   u_if.sw_o,         32'h8);
        check("clean_rise_e6", u_if.sw_rise_o,    e(32'h8));
        check("clean_fall_e6", u_if.sw_fall_o,    32'h0);
        check("clean_chg_e6",  u_if.sw_changed_o, e(32'h8));
        tick(1);
        check("clean_rise_e7", u_if.sw_rise_o,    32'h0);
        tick(3);
        check("clean_sw_hold", u_if.sw_o,         32'h8);
        check("clean_chg_hold",u_if.sw_changed_o, e(32'h8));

        // ---- bounce on bit 0 ----
        do_reset('0);
        tick(2);
        rise0 = n_rise;
        fall0 = n_fall;
        u_if.sw_raw_i = 18'h1; tick(2);
        u_if.sw_raw_i = 18'h0; tick(2);
        u_if.sw_raw_i = 18'h1; tick(2);
        u_if.sw_raw_i = 18'h0; tick(2);
        check("bounce_sw_mid", u_if.sw_o, 32'h0);
        u_if.sw_raw_i = 18'h1;
        tick(LAT - 1);
        check("bounce_sw_e5",  u_if.sw_o, 32'h0);
        tick(1);
        check("bounce_sw_e6",  u_if.sw_o, 32'h1);
        tick(3);
        check("bounce_nrise",  32'(n_rise - rise0), e(32'd1));
        check("bounce_nfall",  32'(n_fall - fall0), 32'd0);
        check("bounce_chg",    u_if.sw_changed_o,   e(32'h1));

        // ---- glitch of DEBOUNCE_CYC-1 cycles on bit 17 ----
        do_reset('0);
        tick(2);
        rise0 = n_rise;
        fall0 = n_fall;
        u_if.sw_raw_i = 18'h20000;
        tick(DEBOUNCE_CYC - 1);
        u_if.sw_raw_i = 18'h0;
        tick(10);
        check("glitch_sw",    u_if.sw_o,          32'h0);
        check("glitch_chg",   u_if.sw_changed_o,  32'h0);
        check("glitch_nrise", 32'(n_rise - rise0), 32'd0);
        check("glitch_nfall", 32'(n_fall - fall0), 32'd0);

        // ---- clear coinciding with a fall on bit 5, bit 2 already set ----
        do_reset('0);
        tick(2);
        u_if.sw_raw_i = 18'h00024;
        tick(LAT + 1);
        check("race_setup_sw",  u_if.sw_o,         32'h24);
        check("race_setup_chg", u_if.sw_changed_o, e(32'h24));
        fall0 = n_fall;
        u_if.sw_raw_i = 18'h00004;
        tick(LAT - 1);
        check("race_sw_e5", u_if.sw_o, 32'h24);
        u_if.clr_i = 1'b1;
        tick(1);
        u_if.clr_i = 1'b0;
        check("race_sw_e6",   u_if.sw_o,         32'h4);
        check("race_fall_e6", u_if.sw_fall_o,    e(32'h20));
        check("race_chg_e6",  u_if.sw_changed_o, e(32'h20));
        tick(2);
        check("race_chg_after", u_if.sw_changed_o, e(32'h20));
        check("race_nfall",     32'(n_fall - fall0), e(32'd1));
        u_if.clr_i = 1'b1;
        tick(1);
        u_if.clr_i = 1'b0;
        check("clr_only_chg", u_if.sw_changed_o, 32'h0);

        // ---- reset pulse in the middle of a debounce on bit 7 ----
        do_reset('0);
        tick(2);
        u_if.sw_raw_i = 18'h00080;
        tick(2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sw", u_if.sw_o, 32'h0);
        tick(1);
        check("mid_rst_sw_hold", u_if.sw_o, 32'h0);
        rst_n = 1'b1;
        tick(LAT - 1);
        check("mid_rst_sw_e5", u_if.sw_o, 32'h0);
        tick(1);
        check("mid_rst_sw_e6",   u_if.sw_o,      32'h80);
        check("mid_rst_rise_e6", u_if.sw_rise_o, e(32'h80));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_input_cond.md
Name: sw_input_cond

Overview:
- Conditions the raw board slide switches before they reach the core's 32-bit switch input (io_sw_i), which is read through the LSU's memory-mapped IO.
- Per switch: 2-flop synchronizer, then counter-based debounce.
- Output is a clean, glitch-free 32-bit word, zero-extended above NUM_SW.
- Optionally also produces per-switch edge pulses and sticky change flags, so software can poll for changes.

Parameters:
- NUM_SW, 18, number of physical switches conditioned; legal 1..32.
- DEBOUNCE_CYC, 500000, consecutive stable cycles required before an output bit flips; legal >= 1 (10 ms at 50 MHz).
- CNT_W (localparam, derived), $clog2(DEBOUNCE_CYC+1), per-switch counter width.

Ports:
- clk_i  input  1  core clock.
- rst_ni  input  1  reset; one clock; asynchronous, active-low.
- sw_raw_i  input  NUM_SW  raw asynchronous switch pins.
- clr_i  input  1  synchronous clear of all sticky change flags.
- sw_o  output  32  debounced switch word; bits [31:NUM_SW] always 0; drives core io_sw_i.
- sw_rise_o  output  32  one-cycle pulse per bit on a debounced 0->1 transition.
- sw_fall_o  output  32  one-cycle pulse per bit on a debounced 1->0 transition.
- sw_changed_o  output  32  sticky per-bit flag; set on any debounced transition.

Behaviour:
- Reset (rst_ni low, async): clears all synchronizer flops, counters, stable values, sw_o, sw_rise_o, sw_fall_o and sw_changed_o to 0.
  - Takes effect immediately, including mid-debounce.
  - A switch already high at reset release produces sw_o=1 and a rise pulse after the normal latency.
- Synchronizer: s1 <= sw_raw_i, s2 <= s1 on every rising edge.
- Debounce, per bit i, with stable[i] driving sw_o[i]:
  - If s2[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYC-1: stable[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Any bounce back to the stable level restarts the count from 0; a glitch shorter than DEBOUNCE_CYC cycles never reaches sw_o.
- Latency: a clean raw change appears on sw_o exactly DEBOUNCE_CYC+2 rising edges after the edge that first samples it (2 synchronizer + DEBOUNCE_CYC).
- Counter never exceeds DEBOUNCE_CYC-1; no wrap-around is possible.
- Edge pulses are registered and go high in the same cycle sw_o[i] first shows the new value, for exactly one cycle.
- Sticky flags:
  - Set in the same cycle as the edge pulse.
  - clr_i clears all flags on the next edge.
  - If clr_i and a new transition on bit i coincide, bit i ends set (set wins); other bits clear.
- All outputs are registers; no combinational path from sw_raw_i or clr_i to any output.
- Bits independent: simultaneous transitions on multiple bits are each handled in the same cycle.

Optional Feature:
- Macro: SW_INPUT_COND_EDGE_EN.
- Defined: sw_rise_o, sw_fall_o and sw_changed_o behave as specified above.
- Undefined:
  - Edge and sticky logic is not synthesized.
  - sw_rise_o, sw_fall_o and sw_changed_o are tied to 0.
  - clr_i is ignored.
  - sw_o behaviour and latency are unchanged.

Test Plan (DEBOUNCE_CYC=4, NUM_SW=18 unless noted):
- Reset: hold rst_ni low with sw_raw_i=18'h3FFFF, release -> all outputs 0 during reset; sw_o=32'h0003FFFF exactly 6 edges after release; sw_rise_o=32'h0003FFFF for one cycle.
- Clean change: raw bit 3 0->1 held -> sw_o[3] rises on edge 6 with a 1-cycle sw_rise_o[3] pulse; sw_changed_o[3]=1 stays set; no other bits change.
- Bounce: raw bit 0 toggles 1,0,1,0 every 2 cycles, then holds 1 -> sw_o[0] rises only 6 edges after the final change; exactly one rise pulse; no fall pulse.
- Glitch rejection: raw bit 17 high for 3 cycles, then low -> sw_o[17] stays 0; no pulses; sw_changed_o[17]=0.
- Sticky clear race: clr_i asserted in the same cycle bit 5 falls, with bit 2 already set -> sw_changed_o[5]=1, sw_changed_o[2]=0 afterwards; sw_fall_o[5] pulses once.
- Reset mid-debounce: raw bit 7 changes, rst_ni pulsed low 2 edges later -> sw_o[7] remains 0 through reset; after release a full 6-edge latency is observed (counter does not resume).
- Macro undefined: repeat the clean-change test -> sw_o identical; sw_rise_o, sw_fall_o and sw_changed_o constant 0.
